// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, default reset PC, fetch FSM states.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE: waiting for a free queue slot; REQ: request held until grant;
    // WAIT: one read outstanding; DROP: outstanding read whose data is stale after a redirect.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are always zero.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue holding {pc, inst} pairs between fetch and decode.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     enq,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_inst,
    input  logic                     deq,
    output logic                     head_valid,
    output logic [XLEN-1:0]          head_pc,
    output logic [XLEN-1:0]          head_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic empty;
    logic full;
    logic do_enq;
    logic do_deq;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_enq = enq && !full && !flush;
    assign do_deq = deq && !empty && !flush;

    // Pointer update; flush wins over any same-cycle enqueue or dequeue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (rdy) begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_enq) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (do_deq) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // Entry storage; contents are only observed through the valid-masked head.
    always_ff @(posedge clk) begin
        if (!rst && rdy && do_enq) begin
            pc_mem[wr_ptr_q[AW-1:0]]   <= enq_pc;
            inst_mem[wr_ptr_q[AW-1:0]] <= enq_inst;
        end
    end

    // Head is masked to zero when empty so stale entries never leak out after flush or reset.
    always_comb begin
        head_valid = !empty;
        head_pc    = '0;
        head_inst  = '0;
        if (!empty) begin
            head_pc   = pc_mem[rd_ptr_q[AW-1:0]];
            head_inst = inst_mem[rd_ptr_q[AW-1:0]];
        end
        count = wr_ptr_q - rd_ptr_q;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues one word read at a time and feeds the decoder queue.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     IQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear,
    input  logic [XLEN-1:0] clear_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_data,
    output logic            to_dec,
    output logic [XLEN-1:0] to_dec_pc,
    output logic [XLEN-1:0] to_dec_inst,
    input  logic            dec_ready
);

    localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(IQ_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;

    logic            iq_flush;
    logic            iq_enq;
    logic            iq_deq;
    logic [CW-1:0]   iq_count;

    fetch_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk        (clk_in),
        .rst        (rst_in),
        .rdy        (rdy_in),
        .flush      (iq_flush),
        .enq        (iq_enq),
        .enq_pc     (addr_q),
        .enq_inst   (mem_data),
        .deq        (iq_deq),
        .head_valid (to_dec),
        .head_pc    (to_dec_pc),
        .head_inst  (to_dec_inst),
        .count      (iq_count)
    );

    // Next-state logic; a redirect overrides every normal transition.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        iq_flush = 1'b0;
        iq_enq   = 1'b0;
        iq_deq   = 1'b0;

        if (clear) begin
            iq_flush = 1'b1;
            pc_d     = align_word(clear_pc);
            unique case (state_q)
                StIdle:         state_d = StIdle;
                // A grant racing the redirect leaves a read in flight to be discarded.
                StReq:          state_d = mem_gnt ? StDrop : StIdle;
                StWait, StDrop: state_d = mem_valid ? StIdle : StDrop;
                default:        state_d = StIdle;
            endcase
        end else begin
            iq_deq = to_dec && dec_ready;
            unique case (state_q)
                StIdle: begin
                    // Only issue when the returning word is guaranteed a slot.
                    if (iq_count < DEPTH_CNT) begin
                        state_d = StReq;
                        addr_d  = pc_q;
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        state_d = StWait;
                        pc_d    = pc_q + XLEN'(4);
                    end
                end
                StWait: begin
                    if (mem_valid) begin
                        state_d = StIdle;
                        iq_enq  = 1'b1;
                    end
                end
                StDrop: begin
                    if (mem_valid) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; rdy_in low freezes everything except reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // Request outputs come straight from registered state.
    always_comb begin
        mem_req  = (state_q == StReq);
        mem_addr = addr_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scenario tasks plus a stream-level reference model.
module tb_instruction_fetch;

    localparam int unsigned IQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [31:0] clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        to_dec;
    logic [31:0] to_dec_pc;
    logic [31:0] to_dec_inst;
    logic        dec_ready;

    instruction_fetch #(
        .IQ_DEPTH (IQ_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .clear_pc    (clear_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .to_dec      (to_dec),
        .to_dec_pc   (to_dec_pc),
        .to_dec_inst (to_dec_inst),
        .dec_ready   (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;

    // Memory responder state (used when auto_mem is set).
    bit          auto_mem;
    bit          rand_gnt;
    int unsigned min_lat;
    int unsigned max_lat;
    bit          pend;
    int unsigned lat;
    logic [31:0] paddr;
    int          gnt_total;

    // Reference model: the decoder must see a strictly sequential stream from exp_pc.
    logic [31:0] exp_pc;
    int          deq_total;

    // Memory image: word at address a. Address 0 holds 32'h00000013 (nop).
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock cycle. At the negedge the memory responder drives its next response and the
    // reference stream consumes the head if a dequeue is about to happen; inputs are then
    // stable across the posedge and the task returns 2 time units after it.
    task automatic tick();
        @(negedge clk);
        if (auto_mem) begin
            mem_gnt   = 1'b0;
            mem_valid = 1'b0;
            if (pend) begin
                if (lat == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = word_at(paddr);
                    pend      = 1'b0;
                end else begin
                    lat--;
                end
            end else if (mem_req && (!rand_gnt || $urandom_range(0, 1) == 1)) begin
                mem_gnt = 1'b1;
                paddr   = mem_addr;
                pend    = 1'b1;
                lat     = $urandom_range(min_lat, max_lat);
                gnt_total++;
            end
        end
        if (rst_in) begin
            exp_pc = RESET_PC;
        end else if (rdy_in) begin
            if (clear) begin
                exp_pc = clear_pc & 32'hFFFF_FFFC;
            end else if (to_dec && dec_ready) begin
                vectors++;
                if (to_dec_pc !== exp_pc || to_dec_inst !== word_at(exp_pc)) begin
                    miscompares++;
                    $display("FAIL stream: got pc=%h inst=%h, expected pc=%h inst=%h",
                             to_dec_pc, to_dec_inst, exp_pc, word_at(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                deq_total++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Hold reset for two edges, quiesce the memory side, then release.
    task automatic apply_reset();
        auto_mem  = 1'b0;
        pend      = 1'b0;
        rand_gnt  = 1'b0;
        min_lat   = 0;
        max_lat   = 0;
        mem_gnt   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        clear     = 1'b0;
        clear_pc  = '0;
        rdy_in    = 1'b1;
        dec_ready = 1'b0;
        rst_in    = 1'b1;
        tick();
        tick();
        rst_in    = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        vectors++;
        if (mem_req !== 1'b0 || to_dec !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got req=%b to_dec=%b, expected 0 0", mem_req, to_dec);
        end
        vectors++;
        if (mem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_addr: got %h, expected %h", mem_addr, RESET_PC);
        end
        vectors++;
        if (to_dec_pc !== 32'h0 || to_dec_inst !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_head: got pc=%h inst=%h, expected 0 0", to_dec_pc, to_dec_inst);
        end
        rst_in = 1'b0;
        tick();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL first_req: got req=%b addr=%h, expected 1 %h",
                     mem_req, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_fetch_sequence();
        int cycles;
        apply_reset();
        dec_ready = 1'b1;
        auto_mem  = 1'b1;
        cycles    = 0;
        while (!to_dec && cycles < 20) begin
            tick();
            cycles++;
        end
        vectors++;
        if (to_dec !== 1'b1 || cycles != 3) begin
            miscompares++;
            $display("FAIL first_fill: got to_dec=%b after %0d cycles, expected 1 after 3",
                     to_dec, cycles);
        end
        vectors++;
        if (to_dec_pc !== 32'h0 || to_dec_inst !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL first_word: got pc=%h inst=%h, expected 0 00000013",
                     to_dec_pc, to_dec_inst);
        end
        // One instruction per three cycles: the third word is at the head six cycles later.
        repeat (6) tick();
        vectors++;
        if (to_dec !== 1'b1 || to_dec_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL throughput: got to_dec=%b pc=%h, expected 1 00000008",
                     to_dec, to_dec_pc);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        int d0;
        int cycles;
        apply_reset();
        g0       = gnt_total;
        auto_mem = 1'b1;
        repeat (20) tick();
        vectors++;
        if (gnt_total - g0 != IQ_DEPTH || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL full_stop: got grants=%0d req=%b, expected %0d 0",
                     gnt_total - g0, mem_req, IQ_DEPTH);
        end
        vectors++;
        if (to_dec !== 1'b1 || to_dec_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL full_head: got to_dec=%b pc=%h, expected 1 0", to_dec, to_dec_pc);
        end
        d0        = deq_total;
        dec_ready = 1'b1;
        cycles    = 0;
        while (!mem_req && cycles < 10) begin
            tick();
            cycles++;
        end
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL resume_addr: got req=%b addr=%h, expected 1 00000010",
                     mem_req, mem_addr);
        end
        cycles = 0;
        while (deq_total - d0 < 5 && cycles < 40) begin
            tick();
            cycles++;
        end
        vectors++;
        if (deq_total - d0 < 5) begin
            miscompares++;
            $display("FAIL resume_drain: got %0d dequeues, expected at least 5", deq_total - d0);
        end
    endtask

    task automatic test_clear_wait();
        int  g0;
        int  cycles;
        bit  seen;
        apply_reset();
        min_lat  = 3;
        max_lat  = 3;
        g0       = gnt_total;
        auto_mem = 1'b1;
        cycles   = 0;
        while (gnt_total - g0 < 2 && cycles < 40) begin
            tick();
            cycles++;
        end
        vectors++;
        if (to_dec !== 1'b1 || mem_req !== 1'b0 || gnt_total - g0 != 2) begin
            miscompares++;
            $display("FAIL clear_setup: got to_dec=%b req=%b grants=%0d, expected 1 0 2",
                     to_dec, mem_req, gnt_total - g0);
        end
        clear    = 1'b1;
        clear_pc = 32'h0000_0100;
        tick();
        clear    = 1'b0;
        vectors++;
        if (to_dec !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_flush: got to_dec=%b, expected 0", to_dec);
        end
        dec_ready = 1'b1;
        seen      = 1'b0;
        cycles    = 0;
        while (!mem_req && cycles < 20) begin
            tick();
            if (to_dec) seen = 1'b1;
            cycles++;
        end
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || seen) begin
            miscompares++;
            $display("FAIL clear_redirect: got req=%b addr=%h stale=%b, expected 1 00000100 0",
                     mem_req, mem_addr, seen);
        end
        cycles = 0;
        while (!to_dec && cycles < 20) begin
            tick();
            cycles++;
        end
        vectors++;
        if (to_dec !== 1'b1 || to_dec_pc !== 32'h100 || to_dec_inst !== word_at(32'h100)) begin
            miscompares++;
            $display("FAIL clear_target: got to_dec=%b pc=%h inst=%h, expected 1 00000100 %h",
                     to_dec, to_dec_pc, to_dec_inst, word_at(32'h100));
        end
    endtask

    task automatic test_clear_collision();
        apply_reset();
        tick();
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        mem_valid = 1'b1;
        mem_data  = word_at(32'h0);
        tick();
        mem_valid = 1'b0;
        tick();
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        vectors++;
        if (to_dec !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL collide_setup: got to_dec=%b req=%b addr=%h, expected 1 0 00000004",
                     to_dec, mem_req, mem_addr);
        end
        // Fill, dequeue and redirect all land on the same edge; low clear_pc bits are dropped.
        mem_valid = 1'b1;
        mem_data  = word_at(32'h4);
        dec_ready = 1'b1;
        clear     = 1'b1;
        clear_pc  = 32'h0000_0043;
        tick();
        mem_valid = 1'b0;
        clear     = 1'b0;
        vectors++;
        if (to_dec !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_flush: got to_dec=%b req=%b, expected 0 0", to_dec, mem_req);
        end
        tick();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL collide_redirect: got req=%b addr=%h, expected 1 00000040",
                     mem_req, mem_addr);
        end
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        mem_valid = 1'b1;
        mem_data  = word_at(32'h40);
        tick();
        mem_valid = 1'b0;
        vectors++;
        if (to_dec !== 1'b1 || to_dec_pc !== 32'h40 || to_dec_inst !== word_at(32'h40)) begin
            miscompares++;
            $display("FAIL collide_target: got to_dec=%b pc=%h inst=%h, expected 1 00000040 %h",
                     to_dec, to_dec_pc, to_dec_inst, word_at(32'h40));
        end
    endtask

    task automatic test_rdy_freeze();
        apply_reset();
        dec_ready = 1'b1;
        tick();
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        // mem_valid while frozen breaks the controller contract: the word must not be captured.
        rdy_in    = 1'b0;
        mem_valid = 1'b1;
        mem_data  = word_at(32'h0);
        tick();
        mem_valid = 1'b0;
        clear     = 1'b1;
        clear_pc  = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem_req !== 1'b0 || to_dec !== 1'b0 || mem_addr !== 32'h0) begin
                miscompares++;
                $display("FAIL freeze_wait: got req=%b to_dec=%b addr=%h, expected 0 0 0",
                         mem_req, to_dec, mem_addr);
            end
            tick();
        end
        clear     = 1'b0;
        rdy_in    = 1'b1;
        mem_valid = 1'b1;
        mem_data  = word_at(32'h0);
        tick();
        mem_valid = 1'b0;
        vectors++;
        if (to_dec !== 1'b1 || to_dec_pc !== 32'h0 || to_dec_inst !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL freeze_resume: got to_dec=%b pc=%h inst=%h, expected 1 0 00000013",
                     to_dec, to_dec_pc, to_dec_inst);
        end
        tick();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL freeze_next: got req=%b addr=%h, expected 1 00000004",
                     mem_req, mem_addr);
        end
        // A grant offered while frozen is not taken; the request stays up.
        rdy_in  = 1'b0;
        mem_gnt = 1'b1;
        tick();
        tick();
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_req: got req=%b, expected 1", mem_req);
        end
        rdy_in  = 1'b1;
        tick();
        mem_gnt = 1'b0;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_grant: got req=%b, expected 0", mem_req);
        end
        mem_valid = 1'b1;
        mem_data  = word_at(32'h4);
        tick();
        mem_valid = 1'b0;
        vectors++;
        if (to_dec !== 1'b1 || to_dec_pc !== 32'h4) begin
            miscompares++;
            $display("FAIL freeze_fill: got to_dec=%b pc=%h, expected 1 00000004",
                     to_dec, to_dec_pc);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        tick();
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        mem_valid = 1'b1;
        mem_data  = word_at(32'h0);
        tick();
        mem_valid = 1'b0;
        tick();
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        vectors++;
        if (to_dec !== 1'b1 || mem_addr !== 32'h4 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_setup: got to_dec=%b addr=%h req=%b, expected 1 00000004 0",
                     to_dec, mem_addr, mem_req);
        end
        rst_in = 1'b1;
        tick();
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== RESET_PC || to_dec !== 1'b0 ||
            to_dec_pc !== 32'h0 || to_dec_inst !== 32'h0) begin
            miscompares++;
            $display("FAIL rstwait_outputs: got req=%b addr=%h to_dec=%b pc=%h inst=%h, expected 0 %h 0 0 0",
                     mem_req, mem_addr, to_dec, to_dec_pc, to_dec_inst, RESET_PC);
        end
        rst_in = 1'b0;
        tick();
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL rstwait_restart: got req=%b addr=%h, expected 1 %h",
                     mem_req, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        int d0;
        apply_reset();
        rand_gnt = 1'b1;
        min_lat  = 0;
        max_lat  = 3;
        auto_mem = 1'b1;
        d0       = deq_total;
        for (int i = 0; i < 3000; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 31) == 0);
            clear_pc  = $urandom;
            tick();
            if (mem_req) begin
                vectors++;
                if (mem_addr[1:0] !== 2'b00) begin
                    miscompares++;
                    $display("FAIL random_align: got addr=%h, expected word aligned", mem_addr);
                end
            end
        end
        clear     = 1'b0;
        dec_ready = 1'b1;
        vectors++;
        if (deq_total - d0 < 100) begin
            miscompares++;
            $display("FAIL random_progress: got %0d dequeues, expected at least 100",
                     deq_total - d0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        gnt_total   = 0;
        deq_total   = 0;
        exp_pc      = RESET_PC;
        auto_mem    = 1'b0;
        rand_gnt    = 1'b0;
        pend        = 1'b0;
        lat         = 0;
        paddr       = '0;
        min_lat     = 0;
        max_lat     = 0;
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        clear       = 1'b0;
        clear_pc    = '0;
        mem_gnt     = 1'b0;
        mem_valid   = 1'b0;
        mem_data    = '0;
        dec_ready   = 1'b0;

        test_reset();
        test_fetch_sequence();
        test_backpressure();
        test_clear_wait();
        test_clear_collision();
        test_rdy_freeze();
        test_reset_in_wait();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by 2000000, expected $finish earlier");
        $fatal(1, "simulation time limit reached");
    end

endmodule
